// File: rtl/mips_isa_pkg.sv
// Shared MIPS-I encoding constants: opcodes, SPECIAL funct codes,
// REGIMM rt codes, COP0 rs codes and the exact eret word.
package mips_isa_pkg;

    // Primary opcode field I[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct field I[5:0]
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // REGIMM rt codes and COP0 rs codes
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;
    localparam logic [4:0] RS_MF   = 5'b00000;
    localparam logic [4:0] RS_MT   = 5'b00100;

    // eret is recognised only as this exact word
    localparam logic [31:0] ERET_WORD = 32'h42000018;

endpackage

// File: rtl/instr_decode.sv
// MIPS-I subset decoder: one-hot per-instruction flags from a 32-bit word,
// plus a registered copy of the reserved-instruction flag.
module instr_decode
    import mips_isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] I,
    output logic lb, lbu, lh, lhu, lw,
    output logic sb, sh, sw,
    output logic R,
    output logic add, addu, sub, subu, mult, multu, div, divu, slt, sltu,
    output logic sll, srl, sra, sllv, srlv, srav,
    output logic and_, or_, xor_, nor_,
    output logic addi, addiu, andi, ori, xori, lui, slti, sltiu,
    output logic beq, bne, blez, bgtz, bltz, bgez,
    output logic j, jal, jalr, jr,
    output logic mfhi, mflo, mthi, mtlo,
    output logic eret, mfc0, mtc0,
    output logic ri,
    output logic ri_r
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;

    assign op    = I[31:26];
    assign rs    = I[25:21];
    assign rt    = I[20:16];
    assign funct = I[5:0];

    // Decode opcode (and funct/rt/rs where the class needs it) into flags
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a flag unassigned, which would otherwise infer a latch.
        {lb, lbu, lh, lhu, lw, sb, sh, sw} = '0;
        {add, addu, sub, subu, mult, multu, div, divu, slt, sltu} = '0;
        {sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_} = '0;
        {addi, addiu, andi, ori, xori, lui, slti, sltiu} = '0;
        {beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr} = '0;
        {mfhi, mflo, mthi, mtlo, eret, mfc0, mtc0} = '0;
        R = (op == OP_SPECIAL);

        case (op)
            OP_SPECIAL: begin
                // Funct-only decode: rs/rt/rd/shamt are deliberately ignored
                case (funct)
                    FN_SLL:   sll   = 1'b1;
                    FN_SRL:   srl   = 1'b1;
                    FN_SRA:   sra   = 1'b1;
                    FN_SLLV:  sllv  = 1'b1;
                    FN_SRLV:  srlv  = 1'b1;
                    FN_SRAV:  srav  = 1'b1;
                    FN_JR:    jr    = 1'b1;
                    FN_JALR:  jalr  = 1'b1;
                    FN_MFHI:  mfhi  = 1'b1;
                    FN_MTHI:  mthi  = 1'b1;
                    FN_MFLO:  mflo  = 1'b1;
                    FN_MTLO:  mtlo  = 1'b1;
                    FN_MULT:  mult  = 1'b1;
                    FN_MULTU: multu = 1'b1;
                    FN_DIV:   div   = 1'b1;
                    FN_DIVU:  divu  = 1'b1;
                    FN_ADD:   add   = 1'b1;
                    FN_ADDU:  addu  = 1'b1;
                    FN_SUB:   sub   = 1'b1;
                    FN_SUBU:  subu  = 1'b1;
                    FN_AND:   and_  = 1'b1;
                    FN_OR:    or_   = 1'b1;
                    FN_XOR:   xor_  = 1'b1;
                    FN_NOR:   nor_  = 1'b1;
                    FN_SLT:   slt   = 1'b1;
                    FN_SLTU:  sltu  = 1'b1;
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                bltz = (rt == RT_BLTZ);
                bgez = (rt == RT_BGEZ);
            end
            OP_COP0: begin
                // ERET_WORD has rs=10000, so it never overlaps mfc0/mtc0
                eret = (I == ERET_WORD);
                mfc0 = (rs == RS_MF);
                mtc0 = (rs == RS_MT);
            end
            OP_J:     j     = 1'b1;
            OP_JAL:   jal   = 1'b1;
            OP_BEQ:   beq   = 1'b1;
            OP_BNE:   bne   = 1'b1;
            OP_BLEZ:  blez  = 1'b1;
            OP_BGTZ:  bgtz  = 1'b1;
            OP_ADDI:  addi  = 1'b1;
            OP_ADDIU: addiu = 1'b1;
            OP_SLTI:  slti  = 1'b1;
            OP_SLTIU: sltiu = 1'b1;
            OP_ANDI:  andi  = 1'b1;
            OP_ORI:   ori   = 1'b1;
            OP_XORI:  xori  = 1'b1;
            OP_LUI:   lui   = 1'b1;
            OP_LB:    lb    = 1'b1;
            OP_LH:    lh    = 1'b1;
            OP_LW:    lw    = 1'b1;
            OP_LBU:   lbu   = 1'b1;
            OP_LHU:   lhu   = 1'b1;
            OP_SB:    sb    = 1'b1;
            OP_SH:    sh    = 1'b1;
            OP_SW:    sw    = 1'b1;
            default: ;
        endcase
    end

    // Reserved instruction: no instruction flag raised (R is a class, not a flag)
    assign ri = ~(lb | lbu | lh | lhu | lw | sb | sh | sw |
                  add | addu | sub | subu | mult | multu | div | divu | slt | sltu |
                  sll | srl | sra | sllv | srlv | srav |
                  and_ | or_ | xor_ | nor_ |
                  addi | addiu | andi | ori | xori | lui | slti | sltiu |
                  beq | bne | blez | bgtz | bltz | bgez |
                  j | jal | jalr | jr |
                  mfhi | mflo | mthi | mtlo |
                  eret | mfc0 | mtc0);

    // Register ri with a synchronous active-low clear
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) ri_r <= 1'b0;
        else        ri_r <= ri;
    end

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: a mnemonic-table reference model
// predicts flags, R, ri and ri_r; a negedge monitor compares.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] I = 32'h0;
    logic lb, lbu, lh, lhu, lw, sb, sh, sw, R;
    logic add, addu, sub, subu, mult, multu, div, divu, slt, sltu;
    logic sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_;
    logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
    logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr;
    logic mfhi, mflo, mthi, mtlo, eret, mfc0, mtc0, ri, ri_r;

    always #5 clk = ~clk;

    instr_decode dut (
        .clk(clk), .reset(reset), .I(I),
        .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw),
        .sb(sb), .sh(sh), .sw(sw), .R(R),
        .add(add), .addu(addu), .sub(sub), .subu(subu), .mult(mult),
        .multu(multu), .div(div), .divu(divu), .slt(slt), .sltu(sltu),
        .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
        .and_(and_), .or_(or_), .xor_(xor_), .nor_(nor_),
        .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori),
        .lui(lui), .slti(slti), .sltiu(sltiu),
        .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
        .j(j), .jal(jal), .jalr(jalr), .jr(jr),
        .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .eret(eret), .mfc0(mfc0), .mtc0(mtc0), .ri(ri), .ri_r(ri_r)
    );

    localparam int NF = 53;
    logic [NF-1:0] dut_flags;
    assign dut_flags = {lb, lbu, lh, lhu, lw, sb, sh, sw,
                        add, addu, sub, subu, mult, multu, div, divu, slt, sltu,
                        sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_,
                        addi, addiu, andi, ori, xori, lui, slti, sltiu,
                        beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                        mfhi, mflo, mthi, mtlo, eret, mfc0, mtc0};
    // flag_names[k] labels dut_flags[NF-1-k]
    string flag_names[NF];

    string op_tbl[logic [5:0]];
    string fn_tbl[logic [5:0]];

    typedef struct {
        logic [31:0]   w;
        string         mn;
        logic [NF-1:0] f;
        logic          r;
        logic          ri;
        logic          rir_chk;
        logic          rir;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;
    logic prev_valid = 1'b0;
    logic prev_rst = 1'b0;
    logic prev_ri = 1'b0;

    task automatic check(input string name, input logic [31:0] w,
                         input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s I=%h got=%h exp=%h", name, w, got, exp);
        end
    endtask

    task automatic init_tables();
        string n[NF] = '{"lb","lbu","lh","lhu","lw","sb","sh","sw",
            "add","addu","sub","subu","mult","multu","div","divu","slt","sltu",
            "sll","srl","sra","sllv","srlv","srav","and_","or_","xor_","nor_",
            "addi","addiu","andi","ori","xori","lui","slti","sltiu",
            "beq","bne","blez","bgtz","bltz","bgez","j","jal","jalr","jr",
            "mfhi","mflo","mthi","mtlo","eret","mfc0","mtc0"};
        flag_names = n;
        op_tbl[6'o40] = "lb";   op_tbl[6'o41] = "lh";   op_tbl[6'o43] = "lw";
        op_tbl[6'o44] = "lbu";  op_tbl[6'o45] = "lhu";
        op_tbl[6'o50] = "sb";   op_tbl[6'o51] = "sh";   op_tbl[6'o53] = "sw";
        op_tbl[6'o10] = "addi"; op_tbl[6'o11] = "addiu"; op_tbl[6'o12] = "slti";
        op_tbl[6'o13] = "sltiu"; op_tbl[6'o14] = "andi"; op_tbl[6'o15] = "ori";
        op_tbl[6'o16] = "xori"; op_tbl[6'o17] = "lui";
        op_tbl[6'o04] = "beq";  op_tbl[6'o05] = "bne";  op_tbl[6'o06] = "blez";
        op_tbl[6'o07] = "bgtz"; op_tbl[6'o02] = "j";    op_tbl[6'o03] = "jal";
        fn_tbl[6'o00] = "sll";  fn_tbl[6'o02] = "srl";  fn_tbl[6'o03] = "sra";
        fn_tbl[6'o04] = "sllv"; fn_tbl[6'o06] = "srlv"; fn_tbl[6'o07] = "srav";
        fn_tbl[6'o10] = "jr";   fn_tbl[6'o11] = "jalr";
        fn_tbl[6'o20] = "mfhi"; fn_tbl[6'o21] = "mthi"; fn_tbl[6'o22] = "mflo";
        fn_tbl[6'o23] = "mtlo"; fn_tbl[6'o30] = "mult"; fn_tbl[6'o31] = "multu";
        fn_tbl[6'o32] = "div";  fn_tbl[6'o33] = "divu";
        fn_tbl[6'o40] = "add";  fn_tbl[6'o41] = "addu"; fn_tbl[6'o42] = "sub";
        fn_tbl[6'o43] = "subu"; fn_tbl[6'o44] = "and_"; fn_tbl[6'o45] = "or_";
        fn_tbl[6'o46] = "xor_"; fn_tbl[6'o47] = "nor_";
        fn_tbl[6'o52] = "slt";  fn_tbl[6'o53] = "sltu";
    endtask

    // Reference model: mnemonic for a word, "" when reserved
    function automatic string ref_decode(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic [5:0] fn = w[5:0];
        if (op == 6'd0) return fn_tbl.exists(fn) ? fn_tbl[fn] : "";
        if (op == 6'd1) begin
            if (w[20:16] == 5'd0) return "bltz";
            if (w[20:16] == 5'd1) return "bgez";
            return "";
        end
        if (op == 6'd16) begin
            if (w == 32'h42000018) return "eret";
            if (w[25:21] == 5'd0) return "mfc0";
            if (w[25:21] == 5'd4) return "mtc0";
            return "";
        end
        return op_tbl.exists(op) ? op_tbl[op] : "";
    endfunction

    // Drive one word for one cycle and push its predicted response
    task automatic apply(input logic [31:0] w, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        I = w;
        reset = rst;
        e.w = w;
        e.mn = ref_decode(w);
        for (int k = 0; k < NF; k++) e.f[NF-1-k] = (flag_names[k] == e.mn);
        e.r = (w[31:26] == 6'd0);
        e.ri = (e.mn == "");
        // ri_r now holds what the last edge sampled: the previous word/reset
        e.rir_chk = prev_valid;
        e.rir = prev_rst ? prev_ri : 1'b0;
        prev_valid = 1'b1;
        prev_rst = rst;
        prev_ri = e.ri;
        q.push_back(e);
    endtask

    // Monitor: combinational outputs are presented each cycle; pop and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({"flags/", e.mn}, e.w, 64'(dut_flags), 64'(e.f));
                check("R", e.w, 64'(R), 64'(e.r));
                check("ri", e.w, 64'(ri), 64'(e.ri));
                if (e.rir_chk) check("ri_r", e.w, 64'(ri_r), 64'(e.rir));
            end
        end
    end

    initial begin
        logic [31:0] w;
        int wait_cycles;
        init_tables();
        // Reset with an illegal word, then release, then a load
        apply(32'h0000003F, 1'b0);
        apply(32'h0000003F, 1'b0);
        apply(32'h0000003F, 1'b1);
        apply(32'h8C820004, 1'b1);
        apply(32'h8C820004, 1'b1);
        // Directed words
        apply(32'hAC820004, 1'b1);
        apply(32'h00851020, 1'b1);
        apply(32'h00000000, 1'b1);
        apply(32'h0000003F, 1'b1);
        apply(32'h04A00003, 1'b1);
        apply(32'h04A10003, 1'b1);
        apply(32'h04A20003, 1'b1);
        apply(32'h42000018, 1'b1);
        apply(32'h40086000, 1'b1);
        apply(32'h40886000, 1'b1);
        apply(32'h42000019, 1'b1);
        // SPECIAL funct sweep with random rs/rt/rd/shamt
        for (int f = 0; f < 64; f++) begin
            w = $urandom;
            w[31:26] = 6'd0;
            w[5:0] = 6'(f);
            apply(w, 1'b1);
        end
        // Every opcode with random low bits
        for (int o = 0; o < 64; o++) begin
            w = $urandom;
            w[31:26] = 6'(o);
            apply(w, 1'b1);
        end
        // REGIMM rt and COP0 rs sweeps
        for (int r = 0; r < 32; r++) begin
            w = $urandom;
            w[31:26] = 6'd1;
            w[20:16] = 5'(r);
            apply(w, 1'b1);
            w = $urandom;
            w[31:26] = 6'd16;
            w[25:21] = 5'(r);
            apply(w, 1'b1);
        end
        // Random words with occasional reset pulses
        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:26] = 6'd0;
            apply(w, ($urandom_range(0, 9) != 0));
        end
        apply(32'h0000003F, 1'b1);
        apply(32'h8C820004, 1'b1);
        wait_cycles = 0;
        while (q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- MIPS-I subset instruction decoder for the 5-stage pipeline; one instance per stage.
- Turns a 32-bit instruction word into one-hot per-instruction flags. Downstream control (PC-source select, hazard, ALU, memory) builds on these flags.
- Flags are purely combinational. One registered reserved-instruction flag uses the clock.

Parameters:
- none

Ports:
- clk  input  1  system clock; used only by ri_r
- reset  input  1  synchronous, active-low (reset==0 clears ri_r on the clk rising edge)
- I  input  32  instruction word
- lb lbu lh lhu lw  output  1 each  load flags
- sb sh sw  output  1 each  store flags
- R  output  1  opcode field == 0 (any SPECIAL-class word)
- add addu sub subu mult multu div divu slt sltu  output  1 each  R-type arith
- sll srl sra sllv srlv srav  output  1 each  shifts
- and_ or_ xor_ nor_  output  1 each  logic
- addi addiu andi ori xori lui slti sltiu  output  1 each  I-type ALU
- beq bne blez bgtz bltz bgez  output  1 each  branches
- j jal jalr jr  output  1 each  jumps
- mfhi mflo mthi mtlo  output  1 each  HI/LO moves
- eret mfc0 mtc0  output  1 each  CP0
- ri  output  1  combinational: no flag above (excluding R) asserted
- ri_r  output  1  ri registered on clk

Behaviour:
- Field definitions: op=I[31:26], rs=I[25:21], rt=I[20:16], funct=I[5:0].
- All decode flags are combinational, zero latency, with no dependence on clk or reset.
- At most one instruction flag is high for any word.
- Loads, by op: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
- Stores, by op: sb 101000, sh 101001, sw 101011.
- I-type, by op: addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, lui 001111.
- Branches and jumps, by op: beq 000100, bne 000101, blez 000110, bgtz 000111, j 000010, jal 000011.
- REGIMM (op 000001): bltz when rt=00000, bgez when rt=00001. Other rt values assert no flag.
- SPECIAL (op 000000) is decoded by funct only:
  - sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111
  - jr 001000, jalr 001001
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
  - mult 011000, multu 011001, div 011010, divu 011011
  - add 100000, addu 100001, sub 100010, subu 100011
  - and_ 100100, or_ 100101, xor_ 100110, nor_ 100111
  - slt 101010, sltu 101011
- SPECIAL funct-only decode: rs/rt/rd/shamt are not checked. 32'h00000000 (nop) therefore asserts sll and R.
- COP0 (op 010000):
  - eret only when I == 32'h42000018 (exact word).
  - mfc0 when rs=00000; mtc0 when rs=00100.
  - Other rs values assert no flag.
- R = (op==000000), regardless of funct.
- ri = 1 when no instruction flag is asserted. This includes an unknown funct under op 000000; R stays 1 for such a word.
- ri_r: on the rising edge of clk, reset==0 loads 0, otherwise it loads ri. One-cycle latency; reset dominates.
- No X propagation: every output is a defined 0/1 for any I.

Decomposition:
- Shared package mips_isa_pkg holds:
  - localparams for all opcode values (OP_SPECIAL, OP_REGIMM, OP_COP0, OP_LW, ...)
  - localparams for all funct values (FN_ADD, ...)
  - REGIMM rt codes, COP0 rs codes (RS_MF=00000, RS_MT=00100)
  - the constant ERET_WORD = 32'h42000018
- No sub-module needed; flat combinational compare logic plus one flop.

Test Plan:
- I=32'h8C820004 (lw) -> lw=1, all other flags 0, R=0, ri=0. I=32'hAC820004 -> sw=1 only.
- I=32'h00851020 (add) -> add=1, R=1. I=32'h00000000 -> sll=1, R=1. I=32'h0000003F -> R=1, ri=1, no instruction flag.
- I=32'h04A00003 -> bltz=1; I=32'h04A10003 -> bgez=1; I=32'h04A20003 -> ri=1.
- I=32'h42000018 -> eret=1; I=32'h40086000 -> mfc0=1; I=32'h40886000 -> mtc0=1; I=32'h42000019 -> ri=1.
- Sweep op=000000 with every one of the 64 funct values, and every legal op value -> exactly one flag high for legal encodings (one-hot check), none for illegal ones.
- reset=0 with I illegal on a clk edge -> ri_r=0; release reset -> ri_r=1 after 1 edge; I=lw on the next edge -> ri_r=0.
